store_sequencer: RTL and testbench

STORE_SEQUENCER -- requirements
Module: store_sequencer

---
 rtl/store_pkg.sv | 23 ++
 rtl/store_lane_align.sv | 33 +++
 rtl/store_sequencer.sv | 163 ++++++++++++++++
 tb/tb_store_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// store_pkg : shared width codes and FSM state encoding for store_sequencer
// Revision  : 1.0
// ============================================================================
package store_pkg;

   typedef enum logic [1:0] {
      WHB_BYTE = 2'b00,
      WHB_HALF = 2'b01,
      WHB_WORD = 2'b10,
      WHB_ILL  = 2'b11
   } whb_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BEAT0 = 2'b01,
      BEAT1 = 2'b10,
      FIN   = 2'b11
   } state_e;

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
// store_lane_align : shifts store data and byte mask onto a two-word lane view
// Revision         : 1.0
// ============================================================================
module store_lane_align
   import store_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  whb,
   input  logic [1:0]  off,
   output logic [63:0] wide,
   output logic [7:0]  mask
);

   logic [31:0] ext;
   logic [3:0]  m;

   always_comb begin
      ext = 32'd0;
      m   = 4'b0000;
      case (whb)
         WHB_BYTE: begin ext = {24'd0, data[7:0]};  m = 4'b0001; end
         WHB_HALF: begin ext = {16'd0, data[15:0]}; m = 4'b0011; end
         WHB_WORD: begin ext = data;                m = 4'b1111; end
         default:  begin ext = 32'd0;               m = 4'b0000; end
      endcase
      wide = {32'd0, ext} << {off, 3'b000};
      mask = {4'b0000, m} << off;
   end

endmodule
`default_nettype wire

// File: rtl/store_sequencer.sv
`default_nettype none
// ============================================================================
// store_sequencer : splits a byte/half/word store into one or two aligned beats
// Revision        : 1.0
// ============================================================================
module store_sequencer
   import store_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_whb,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        done,
   output logic        err
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [1:0]        whb_q, whb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gap_q, gap_d;
   logic              err_q, err_d;

   logic [63:0]       wide;
   logic [7:0]        mask;
   logic [31:0]       base_addr;

   store_lane_align u_align (
      .data (data_q),
      .whb  (whb_q),
      .off  (addr_q[1:0]),
      .wide (wide),
      .mask (mask)
   );

   assign base_addr = {addr_q[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         whb_q   <= 2'b00;
         cnt_q   <= '0;
         gap_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         whb_q   <= whb_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      whb_d     = whb_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      err_d     = err_q;
      req_ready = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_be    = 4'b0000;
      done      = 1'b0;
      err       = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d = req_addr;
               data_d = req_data;
               whb_d  = req_whb;
               cnt_d  = '0;
               gap_d  = 1'b0;
               if (req_whb == WHB_ILL) begin
                  state_d = FIN;
                  err_d   = 1'b1;
               end else begin
                  state_d = BEAT0;
                  err_d   = 1'b0;
               end
            end
         end

         BEAT0: begin
            mem_we    = 1'b1;
            mem_addr  = base_addr;
            mem_wdata = wide[31:0];
            mem_be    = mask[3:0];
            if (mem_ack) begin
               cnt_d = '0;
               if (mask[7:4] != 4'b0000) begin
                  state_d = BEAT1;
                  gap_d   = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         BEAT1: begin
            // First BEAT1 cycle is the idle gap after the BEAT0 ack; acks here are ignored.
            if (gap_q) begin
               gap_d = 1'b0;
            end else begin
               mem_we    = 1'b1;
               mem_addr  = base_addr + 32'd4;
               mem_wdata = wide[63:32];
               mem_be    = mask[7:4];
               if (mem_ack) begin
                  cnt_d   = '0;
                  state_d = FIN;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  err_d   = 1'b1;
                  state_d = FIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         FIN: begin
            done    = 1'b1;
            err     = err_q;
            err_d   = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_store_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_store_sequencer : directed self-checking bench for store_sequencer
// Revision           : 1.0
// ============================================================================
module tb_store_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_whb;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_sequencer #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_whb   (req_whb),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .done      (done),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_bus(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
      chk({tag, ".we"},    {31'd0, mem_we}, {31'd0, we});
      chk({tag, ".addr"},  mem_addr, a);
      chk({tag, ".wdata"}, mem_wdata, d);
      chk({tag, ".be"},    {28'd0, mem_be}, {28'd0, be});
   endtask

   task automatic chk_fin(input string tag, input logic d, input logic e);
      chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
      chk({tag, ".err"},  {31'd0, err},  {31'd0, e});
   endtask

   task automatic send(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_whb   = w;
      chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      req_data  = 32'd0;
      req_whb   = 2'b00;
      mem_ack   = 1'b0;

      // Reset values
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk_bus("rst", 1'b0, 32'd0, 32'd0, 4'b0000);
      chk_fin("rst", 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.ready", {31'd0, req_ready}, 32'd1);

      // Byte store at 0x103: single beat in the top lane
      send("byte", 32'h0000_0103, 32'h0000_00AB, 2'b00);
      chk_bus("byte.b0", 1'b1, 32'h0000_0100, 32'hAB00_0000, 4'b1000);
      chk("byte.b0.ready", {31'd0, req_ready}, 32'd0);
      chk_fin("byte.b0", 1'b0, 1'b0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("byte.fin.we", {31'd0, mem_we}, 32'd0);
      chk_fin("byte.fin", 1'b1, 1'b0);
      tick();
      chk_fin("byte.idle", 1'b0, 1'b0);
      chk("byte.idle.ready", {31'd0, req_ready}, 32'd1);

      // Word store at 0x202: split across two beats, ack held through the gap
      send("word", 32'h0000_0202, 32'h1122_3344, 2'b10);
      chk_bus("word.b0", 1'b1, 32'h0000_0200, 32'h3344_0000, 4'b1100);
      mem_ack = 1'b1;
      tick();
      chk("word.gap.we", {31'd0, mem_we}, 32'd0);
      chk_fin("word.gap", 1'b0, 1'b0);
      tick();
      mem_ack = 1'b0;
      chk_bus("word.b1", 1'b1, 32'h0000_0204, 32'h0000_1122, 4'b0011);
      tick();
      chk_bus("word.b1.hold", 1'b1, 32'h0000_0204, 32'h0000_1122, 4'b0011);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("word.fin.we", {31'd0, mem_we}, 32'd0);
      chk_fin("word.fin", 1'b1, 1'b0);
      tick();

      // Half store at 0x7, ack on the third cycle of each beat
      send("half", 32'h0000_0007, 32'h0000_BEEF, 2'b01);
      for (int i = 0; i < 3; i++) begin
         chk_bus("half.b0", 1'b1, 32'h0000_0004, 32'hEF00_0000, 4'b1000);
         if (i == 2) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      chk("half.gap.we", {31'd0, mem_we}, 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk_bus("half.b1", 1'b1, 32'h0000_0008, 32'h0000_00BE, 4'b0001);
         if (i == 2) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      chk_fin("half.fin", 1'b1, 1'b0);
      tick();

      // Illegal width: no beat, done+err straight away
      send("ill", 32'h0000_0010, 32'h1234_5678, 2'b11);
      chk("ill.we", {31'd0, mem_we}, 32'd0);
      chk("ill.ready", {31'd0, req_ready}, 32'd0);
      chk_fin("ill.fin", 1'b1, 1'b1);
      tick();
      chk_fin("ill.idle", 1'b0, 1'b0);
      chk("ill.idle.ready", {31'd0, req_ready}, 32'd1);

      // Timeout: no ack, mem_we high for exactly TIMEOUT cycles
      send("to", 32'h0000_0040, 32'hCAFE_F00D, 2'b10);
      n = 0;
      while (mem_we === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk("to.cycles", n, 32'd16);
      chk_fin("to.fin", 1'b1, 1'b1);
      tick();
      chk_fin("to.idle", 1'b0, 1'b0);
      chk("to.idle.ready", {31'd0, req_ready}, 32'd1);

      // Ack on the last allowed cycle counts as success
      send("late", 32'h0000_0010, 32'h0000_005A, 2'b00);
      for (int i = 0; i < 15; i++) tick();
      chk_bus("late.b0", 1'b1, 32'h0000_0010, 32'h0000_005A, 4'b0001);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk_fin("late.fin", 1'b1, 1'b0);
      tick();

      // Second beat address wraps at the top of the address space
      send("wrap", 32'hFFFF_FFFF, 32'h0000_1234, 2'b01);
      chk_bus("wrap.b0", 1'b1, 32'hFFFF_FFFC, 32'h3400_0000, 4'b1000);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      chk_bus("wrap.b1", 1'b1, 32'h0000_0000, 32'h0000_0012, 4'b0001);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk_fin("wrap.fin", 1'b1, 1'b0);
      tick();

      // Reset asserted mid BEAT1 of a split word store
      send("rb", 32'h0000_0202, 32'h1122_3344, 2'b10);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      chk_bus("rb.b1", 1'b1, 32'h0000_0204, 32'h0000_1122, 4'b0011);
      #2;
      rst_n = 1'b0;
      #1;
      chk_bus("rb.async", 1'b0, 32'd0, 32'd0, 4'b0000);
      chk("rb.async.done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rb.rel.ready", {31'd0, req_ready}, 32'd1);
      chk_fin("rb.rel", 1'b0, 1'b0);
      tick();
      chk_fin("rb.after", 1'b0, 1'b0);
      chk("rb.after.we", {31'd0, mem_we}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
